// File: rtl/dnn_sample_scheduler.sv
// dnn_sample_scheduler: owns block-cycle timing and feeds one sample per block,
// tagging each sample through the DNN latency and scoring its prediction.
module dnn_sample_scheduler #(
   parameter  int width_in   = 8,
   parameter  int n0         = 1024,
   parameter  int nL         = 64,
   parameter  int z0         = 128,
   parameter  int fo0        = 8,
   parameter  int zL         = 4,
   parameter  int fiL        = 4,
   parameter  int ec         = 2,
   parameter  int out_lat    = 3,
   parameter  int etapos_w   = 4,
   parameter  int etapos_max = 9,
   localparam int chunks     = n0 * fo0 / z0,
   localparam int cpc        = chunks + ec,
   localparam int abyc       = z0 / fo0,
   localparam int zbyfi      = zL / fiL,
   localparam int aw         = $clog2(65536),
   localparam int cw         = $clog2(cpc),
   localparam int lw         = $clog2(nL)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [15:0]               num_samples,
   input  logic [aw-1:0]             base_addr,
   input  logic [etapos_w-1:0]       cfg_etapos,
   input  logic                      pause,
   output logic                      mem_rd_en,
   output logic [aw-1:0]             mem_addr,
   input  logic [abyc*width_in-1:0]  mem_act,
   input  logic [lw-1:0]             mem_label,
   output logic [abyc*width_in-1:0]  dnn_act0,
   output logic [zbyfi-1:0]          dnn_ans0,
   output logic [etapos_w-1:0]       dnn_etapos0,
   output logic [cw-1:0]             cycle_index,
   output logic                      cycle_clk,
   input  logic [nL-1:0]             actL_alln,
   output logic                      busy,
   output logic                      done,
   output logic                      result_valid,
   output logic                      result_correct,
   output logic [lw-1:0]             result_pred,
   output logic [15:0]               correct_cnt
);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

   state_t              state;
   logic [cw-1:0]       cyc;
   logic                smp;
   logic [15:0]         s_cnt;
   logic [15:0]         n_lat;
   logic [aw-1:0]       blk_addr;
   logic [etapos_w-1:0] eta_lat;
   logic [lw-1:0]       lbl;
   logic [7:0]          drn;
   logic                tv [out_lat];
   logic [lw-1:0]       tl [out_lat];

   logic                run;
   logic                last;
   logic                is_smp;
   logic                dat;
   logic [15:0]         s_nxt;
   logic [lw-1:0]       lbl_now;
   logic [lw-1:0]       pred;
   logic [nL-1:0]       want;
   logic                hit;

   if (nL / zbyfi != chunks) begin : g_chk
      $error("nL/zbyfi must equal chunks");
   end

   assign run     = (state == FEED) || (state == DRAIN);
   assign last    = (cyc == cw'(cpc - 1));
   assign is_smp  = (state == FEED) && smp;
   assign dat     = is_smp && (cyc != '0) && (cyc <= cw'(chunks));
   assign s_nxt   = s_cnt + {15'd0, smp};
   // label register is loaded at c=1, so that clock uses the memory label directly
   assign lbl_now = (cyc == cw'(1)) ? mem_label : lbl;

   assign cycle_index = cyc;
   assign cycle_clk   = run && (cyc < cw'(cpc / 2));
   assign mem_rd_en   = is_smp && (cyc < cw'(chunks));
   assign mem_addr    = mem_rd_en ? blk_addr + aw'(cyc) : '0;
   assign dnn_act0    = dat ? mem_act : '0;
   assign dnn_etapos0 = is_smp ? eta_lat : etapos_w'(etapos_max);

   always_comb begin
      dnn_ans0 = '0;
      for (int j = 0; j < zbyfi; j++)
         dnn_ans0[j] = dat &&
            (int'(lbl_now) == (int'(cyc) - 1) * zbyfi + j);
   end

   always_comb begin
      pred = '0;
      for (int i = nL - 1; i >= 0; i--)
         if (actL_alln[i]) pred = lw'(i);
      want = '0;
      want[tl[out_lat-1]] = 1'b1;
      hit = (actL_alln == want);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         cyc            <= '0;
         smp            <= 1'b0;
         s_cnt          <= '0;
         n_lat          <= '0;
         blk_addr       <= '0;
         eta_lat        <= '0;
         lbl            <= '0;
         drn            <= '0;
         for (int k = 0; k < out_lat; k++) begin
            tv[k] <= 1'b0;
            tl[k] <= '0;
         end
         busy           <= 1'b0;
         done           <= 1'b0;
         result_valid   <= 1'b0;
         result_correct <= 1'b0;
         result_pred    <= '0;
         correct_cnt    <= '0;
      end else begin
         result_valid <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  n_lat       <= num_samples;
                  blk_addr    <= base_addr;
                  eta_lat     <= cfg_etapos;
                  s_cnt       <= '0;
                  cyc         <= '0;
                  correct_cnt <= '0;
                  if (num_samples == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= FEED;
                     smp   <= 1'b1;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end
               end
            end
            default: begin
               cyc <= last ? '0 : cyc + cw'(1);
               if (is_smp && cyc == cw'(1)) lbl <= mem_label;
               if (last) begin
                  tv[0] <= is_smp;
                  tl[0] <= lbl;
                  for (int k = 1; k < out_lat; k++) begin
                     tv[k] <= tv[k-1];
                     tl[k] <= tl[k-1];
                  end
                  if (tv[out_lat-1]) begin
                     result_valid   <= 1'b1;
                     result_pred    <= pred;
                     result_correct <= hit;
                     if (hit && correct_cnt != 16'hFFFF)
                        correct_cnt <= correct_cnt + 16'd1;
                  end
                  if (state == FEED) begin
                     if (smp) begin
                        s_cnt    <= s_nxt;
                        blk_addr <= blk_addr + aw'(chunks);
                     end
                     if (s_nxt == n_lat) begin
                        state <= DRAIN;
                        smp   <= 1'b0;
                        drn   <= '0;
                     end else begin
                        smp <= !pause;
                     end
                  end else begin
                     drn <= drn + 8'd1;
                     if (drn == 8'(out_lat - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dnn_sample_scheduler.sv
// tb_dnn_sample_scheduler: table of directed runs checked clock by clock,
// plus reset and idle sequences.
module tb_dnn_sample_scheduler;

   localparam int AW  = 16;
   localparam int CW  = 7;
   localparam int LW  = 6;
   localparam int NL  = 64;

   logic           clk;
   logic           reset;
   logic           start;
   logic [15:0]    num_samples;
   logic [AW-1:0]  base_addr;
   logic [3:0]     cfg_etapos;
   logic           pause;
   logic           mem_rd_en;
   logic [AW-1:0]  mem_addr;
   logic [127:0]   mem_act;
   logic [LW-1:0]  mem_label;
   logic [127:0]   dnn_act0;
   logic [0:0]     dnn_ans0;
   logic [3:0]     dnn_etapos0;
   logic [CW-1:0]  cycle_index;
   logic           cycle_clk;
   logic [NL-1:0]  actL_alln;
   logic           busy;
   logic           done;
   logic           result_valid;
   logic           result_correct;
   logic [LW-1:0]  result_pred;
   logic [15:0]    correct_cnt;

   dnn_sample_scheduler dut (
      .clk(clk), .reset(reset), .start(start),
      .num_samples(num_samples), .base_addr(base_addr),
      .cfg_etapos(cfg_etapos), .pause(pause),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_act(mem_act), .mem_label(mem_label),
      .dnn_act0(dnn_act0), .dnn_ans0(dnn_ans0),
      .dnn_etapos0(dnn_etapos0), .cycle_index(cycle_index),
      .cycle_clk(cycle_clk), .actL_alln(actL_alln),
      .busy(busy), .done(done), .result_valid(result_valid),
      .result_correct(result_correct), .result_pred(result_pred),
      .correct_cnt(correct_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cur_run = 0;
   int cur_k = 0;
   int cur_base = 0;
   int lab_m [8];
   int prd_m [8];
   int midx;

   function automatic logic [127:0] pat(input int a);
      logic [15:0] a16;
      a16 = a[15:0];
      return {8{a16}};
   endfunction

   // sample memory: 1-clock latency, junk when not read
   always @(posedge clk) begin
      midx = (int'(mem_addr) - cur_base) >>> 6;
      mem_act <= mem_rd_en ? pat(int'(mem_addr)) : '1;
      mem_label <= (mem_rd_en && midx >= 0 && midx < 8) ?
                   6'(lab_m[midx]) : 6'h2A;
   end

   task automatic chk(input string name, input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s run=%0d k=%0d got=%0h exp=%0h",
                  name, cur_run, cur_k, got, exp);
      end
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_cycle_index"}, cycle_index, 0);
      chk({tag, "_cycle_clk"}, cycle_clk, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_mem_rd_en"}, mem_rd_en, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_dnn_act0"}, dnn_act0, 0);
      chk({tag, "_dnn_ans0"}, dnn_ans0, 0);
      chk({tag, "_dnn_etapos0"}, dnn_etapos0, 9);
      chk({tag, "_result_valid"}, result_valid, 0);
      chk({tag, "_result_correct"}, result_correct, 0);
      chk({tag, "_result_pred"}, result_pred, 0);
      chk({tag, "_correct_cnt"}, correct_cnt, 0);
   endtask

   typedef struct {
      int n;
      int base;
      int eta;
      int pause_at;
      bit pdrain;
      bit restart;
      int l0, l1, l2;
      int p0, p1, p2;
      int exp_cnt;
      int exp_len;
   } run_t;

   run_t tbl [7];

   task automatic do_run(input run_t r);
      int nbub, nfeed, len, sc, blk, c, s, fb;
      bit smp_e, rv_e, running, rd_e;
      logic [63:0] one;
      one = 64'd1;
      for (int i = 0; i < 8; i++) begin
         lab_m[i] = 0;
         prd_m[i] = 64;
      end
      lab_m[0] = r.l0; lab_m[1] = r.l1; lab_m[2] = r.l2;
      prd_m[0] = r.p0; prd_m[1] = r.p1; prd_m[2] = r.p2;
      cur_base = r.base;
      nbub = (r.pause_at >= 0) ? 1 : 0;
      nfeed = r.n + nbub;
      len = r.exp_len;
      sc = 0;
      actL_alln = (prd_m[0] == 64) ? '0 : one << prd_m[0];
      num_samples = 16'(r.n);
      base_addr = 16'(r.base);
      cfg_etapos = 4'(r.eta);
      pause = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= len; k++) begin
         cur_k = k;
         blk = (k - 1) / 66;
         c = (k - 1) % 66;
         running = (k < len);
         smp_e = running && blk < nfeed &&
                 !(nbub == 1 && blk == r.pause_at + 1);
         s = (nbub == 1 && blk > r.pause_at + 1) ? blk - 1 : blk;
         rd_e = smp_e && c < 64;
         rv_e = 1'b0;
         for (int q = 0; q < r.n && q < 3; q++) begin
            fb = (nbub == 1 && q > r.pause_at) ? q + 1 : q;
            if (k == (fb + 4) * 66 + 1) rv_e = 1'b1;
         end
         chk("cycle_index", cycle_index, running ? c : 0);
         chk("cycle_clk", cycle_clk, running && c < 33);
         chk("busy", busy, running);
         chk("done", done, k == len);
         chk("mem_rd_en", mem_rd_en, rd_e);
         if (rd_e) chk("mem_addr", mem_addr, r.base + s * 64 + c);
         chk("dnn_etapos0", dnn_etapos0, smp_e ? r.eta : 9);
         chk("dnn_ans0", dnn_ans0,
             smp_e && c >= 1 && c <= 64 && lab_m[s] == c - 1);
         chk("dnn_act0", dnn_act0,
             (smp_e && c >= 1 && c <= 64) ?
             pat(r.base + s * 64 + c - 1) : '0);
         chk("result_valid", result_valid, rv_e);
         if (rv_e) begin
            chk("result_pred", result_pred,
                prd_m[sc] == 64 ? 0 : prd_m[sc]);
            chk("result_correct", result_correct,
                prd_m[sc] == lab_m[sc]);
            sc++;
            actL_alln = (sc < r.n && prd_m[sc] != 64) ?
                        one << prd_m[sc] : '0;
         end
         if (k == len) chk("correct_cnt", correct_cnt, r.exp_cnt);
         else if (k == 1) chk("correct_cnt_clr", correct_cnt, 0);
         pause = running && (blk == r.pause_at ||
                             (r.pdrain && blk >= nfeed));
         start = r.restart && k == 100;
         if (start) begin
            num_samples = 16'd5;
            base_addr = 16'd999;
         end
         if (k < len) begin
            @(posedge clk); #1;
         end
      end
      start = 1'b0;
      pause = 1'b0;
   endtask

   initial begin
      int bad;
      tbl[0] = '{2, 0,   3, -1, 1'b0, 1'b0, 5, 63, 0,  5, 63, 0,  2, 331};
      tbl[1] = '{3, 0,   5,  0, 1'b0, 1'b0, 1, 2, 3,   1, 2, 3,    3, 463};
      tbl[2] = '{0, 0,   6, -1, 1'b0, 1'b0, 0, 0, 0,   0, 0, 0,    0, 1};
      tbl[3] = '{1, 0,  12, -1, 1'b0, 1'b1, 8, 0, 0,   7, 0, 0,    0, 265};
      tbl[4] = '{2, 128, 7, -1, 1'b1, 1'b0, 0, 62, 0,  64, 62, 0,  1, 331};
      tbl[5] = '{3, 64,  0,  1, 1'b0, 1'b0, 10, 20, 30, 10, 21, 30, 2, 463};
      tbl[6] = '{1, 0,  15, -1, 1'b0, 1'b0, 63, 0, 0,  63, 0, 0,   1, 265};

      reset = 1'b1;
      start = 1'b0;
      pause = 1'b0;
      num_samples = '0;
      base_addr = '0;
      cfg_etapos = '0;
      actL_alln = '0;
      for (int i = 0; i < 8; i++) begin
         lab_m[i] = 0;
         prd_m[i] = 64;
      end
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_rst("por");
      reset = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         cur_run = i;
         do_run(tbl[i]);
      end

      // reset landing mid-stream with valid tags in flight
      cur_run = 100;
      lab_m[0] = 4; lab_m[1] = 5; lab_m[2] = 6;
      cur_base = 0;
      num_samples = 16'd3;
      base_addr = '0;
      cfg_etapos = 4'd4;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (200) @(posedge clk);
      #2 reset = 1'b0;
      #1 chk_rst("mid");
      @(posedge clk); #1;
      chk("rst_hold_cycle_index", cycle_index, 0);
      reset = 1'b1;
      bad = 0;
      repeat (300) begin
         @(posedge clk); #1;
         if (result_valid || busy || done) bad++;
      end
      chk("post_reset_idle", bad, 0);

      cur_run = 6;
      do_run(tbl[6]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
